// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - sequential signed NxN shift-add multiplier, integer and Q1.(N-1) modes
//
// Sits downstream of the register file: a/b come from rdata1/rdata2, result
// feeds wdata and done acts as the write enable.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   operation request, sampled only while idle
//   frac     in   1 = fractional Q1.(N-1) with saturation, 0 = integer (low N bits)
//   a, b     in   signed operands, latched with start
//   busy     out  high whenever an operation is in flight
//   done     out  one-cycle pulse, result/product valid
//   result   out  mode-selected N-bit result, held until next completion
//   product  out  full signed 2N-bit product, held until next completion

module mul_unit #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             frac,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     result,
  output logic [2*N-1:0]   product
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
  localparam logic [N-1:0]  FRAC_MAX  = {1'b0, {(N-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           sign_q;
  logic           frac_q;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [2*N-1:0] signed_prod;
  logic           frac_ovf;
  logic [N-1:0]   result_nx;

  // Unsigned magnitudes: -2^(N-1) negates to itself, which read as unsigned
  // is exactly 2^(N-1), so no extra bit is needed.
  assign a_mag = a[N-1] ? -a : a;
  assign b_mag = b[N-1] ? -b : b;

  assign signed_prod = sign_q ? -acc : acc;

  // The Q1.(N-1) window drops the top bit; if the top two bits disagree the
  // value is not representable. Only (-1)*(-1) can get here, and it is positive.
  assign frac_ovf = signed_prod[2*N-1] ^ signed_prod[2*N-2];

  always_comb begin
    result_nx = signed_prod[N-1:0];
    if (frac_q) begin
      result_nx = frac_ovf ? FRAC_MAX : signed_prod[2*N-2:N-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (cnt == LAST_STEP) state_nx = SIGN;
      SIGN: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      frac_q  <= 1'b0;
      result  <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{N{1'b0}}, a_mag};
            mplier <= b_mag;
            sign_q <= a[N-1] ^ b[N-1];
            frac_q <= frac;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        SIGN: begin
          product <= signed_prod;
          result  <= result_nx;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - self-checking bench for mul_unit with a result scoreboard

module tb_mul_unit;

  localparam int N = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic           frac;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [N-1:0]   result;
  logic [2*N-1:0] product;

  int total;
  int bad;

  // Each entry: {product[15:0], result[7:0]}
  logic [23:0] sb[$];
  logic [23:0] mon_exp;

  mul_unit #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .frac    (frac),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mf);
    logic signed [15:0] p;
    logic [15:0] pu;
    logic [7:0] r;
    p  = $signed(ma) * $signed(mb);
    pu = p;
    if (mf) begin
      if (pu == 16'h4000) r = 8'h7F;
      else r = pu[14:7];
    end else begin
      r = pu[7:0];
    end
    return {pu, r};
  endfunction

  // Scoreboard: every done pulse pops one expected entry.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        total += 1;
        bad += 1;
        $display("FAIL unexpected_done: done=1 with no operation pending, product=%h result=%h", product, result);
      end else begin
        mon_exp = sb.pop_front();
        total += 1;
        if (product !== mon_exp[23:8]) begin
          bad += 1;
          $display("FAIL product: got=%h expected=%h", product, mon_exp[23:8]);
        end
        total += 1;
        if (result !== mon_exp[7:0]) begin
          bad += 1;
          $display("FAIL result: got=%h expected=%h", result, mon_exp[7:0]);
        end
      end
    end
  end

  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic of, output bit ok);
    @(negedge clk);
    a = oa; b = ob; frac = of; start = 1'b1;
    sb.push_back(model(oa, ob, of));
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total += 1;
    if (busy !== 1'b0) begin bad += 1; $display("FAIL reset_busy: got=%b expected=0", busy); end
    total += 1;
    if (done !== 1'b0) begin bad += 1; $display("FAIL reset_done: got=%b expected=0", done); end
    total += 1;
    if (result !== 8'h00) begin bad += 1; $display("FAIL reset_result: got=%h expected=00", result); end
    total += 1;
    if (product !== 16'h0000) begin bad += 1; $display("FAIL reset_product: got=%h expected=0000", product); end
  endtask

  task automatic test_int_latency;
    int done_at;
    int busy_cnt;
    int ndone;
    done_at = -1; busy_cnt = 0; ndone = 0;
    @(negedge clk);
    a = 8'h07; b = 8'h06; frac = 1'b0; start = 1'b1;
    sb.push_back(model(8'h07, 8'h06, 1'b0));
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
    end
    total += 1;
    if (done_at != 10) begin bad += 1; $display("FAIL latency_done_cycle: got=%0d expected=10", done_at); end
    total += 1;
    if (busy_cnt != 10) begin bad += 1; $display("FAIL latency_busy_cycles: got=%0d expected=10", busy_cnt); end
    total += 1;
    if (ndone != 1) begin bad += 1; $display("FAIL latency_done_pulses: got=%0d expected=1", ndone); end
  endtask

  task automatic test_signed;
    bit ok;
    run_op(8'hFD, 8'h05, 1'b0, ok);
    total += 1;
    if (!ok) begin bad += 1; $display("FAIL signed_timeout: done got=0 expected=1"); end
    run_op(8'h00, 8'h9C, 1'b0, ok);
    total += 1;
    if (!ok) begin bad += 1; $display("FAIL zero_timeout: done got=0 expected=1"); end
    for (int i = 0; i < 4; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), ok);
      total += 1;
      if (!ok) begin bad += 1; $display("FAIL random_timeout[%0d]: done got=0 expected=1", i); end
    end
  endtask

  task automatic test_frac;
    bit ok;
    run_op(8'h40, 8'h40, 1'b1, ok);
    total += 1;
    if (!ok) begin bad += 1; $display("FAIL frac_pos_timeout: done got=0 expected=1"); end
    run_op(8'hC0, 8'h40, 1'b1, ok);
    total += 1;
    if (!ok) begin bad += 1; $display("FAIL frac_neg_timeout: done got=0 expected=1"); end
  endtask

  task automatic test_saturation;
    bit ok;
    run_op(8'h80, 8'h80, 1'b1, ok);
    total += 1;
    if (!ok) begin bad += 1; $display("FAIL sat_frac_timeout: done got=0 expected=1"); end
    run_op(8'h80, 8'h80, 1'b0, ok);
    total += 1;
    if (!ok) begin bad += 1; $display("FAIL sat_int_timeout: done got=0 expected=1"); end
    run_op(8'h80, 8'h7F, 1'b1, ok);
    total += 1;
    if (!ok) begin bad += 1; $display("FAIL sat_edge_timeout: done got=0 expected=1"); end
  endtask

  task automatic test_busy_start;
    int ndone;
    ndone = 0;
    @(negedge clk);
    a = 8'h11; b = 8'h03; frac = 1'b0; start = 1'b1;
    sb.push_back(model(8'h11, 8'h03, 1'b0));
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        start = 1'b1; a = 8'h55; b = 8'h22; frac = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) ndone++;
    end
    total += 1;
    if (ndone != 1) begin bad += 1; $display("FAIL busy_ignore_pulses: got=%0d expected=1", ndone); end
    total += 1;
    if (busy !== 1'b0) begin bad += 1; $display("FAIL busy_ignore_idle: busy got=%b expected=0", busy); end
  endtask

  task automatic test_back_to_back;
    int idx[3];
    int nd;
    int extra;
    nd = 0; extra = 0;
    idx[0] = 0; idx[1] = 0; idx[2] = 0;
    @(negedge clk);
    a = 8'h05; b = 8'h09; frac = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model(8'h05, 8'h09, 1'b0));
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        idx[nd] = k;
        nd++;
        if (nd == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    total += 1;
    if (nd != 3) begin bad += 1; $display("FAIL b2b_pulses: got=%0d expected=3", nd); end
    total += 1;
    if (idx[0] != 10) begin bad += 1; $display("FAIL b2b_first_done: got=%0d expected=10", idx[0]); end
    total += 1;
    if (idx[1] - idx[0] != 11) begin bad += 1; $display("FAIL b2b_gap1: got=%0d expected=11", idx[1] - idx[0]); end
    total += 1;
    if (idx[2] - idx[1] != 11) begin bad += 1; $display("FAIL b2b_gap2: got=%0d expected=11", idx[2] - idx[1]); end
    total += 1;
    if (extra != 0) begin bad += 1; $display("FAIL b2b_extra_done: got=%0d expected=0", extra); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    @(negedge clk);
    a = 8'h7F; b = 8'h7F; frac = 1'b0; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    total += 1;
    if (busy !== 1'b0) begin bad += 1; $display("FAIL midreset_busy: got=%b expected=0", busy); end
    total += 1;
    if (done !== 1'b0) begin bad += 1; $display("FAIL midreset_done: got=%b expected=0", done); end
    total += 1;
    if (result !== 8'h00) begin bad += 1; $display("FAIL midreset_result: got=%h expected=00", result); end
    total += 1;
    if (product !== 16'h0000) begin bad += 1; $display("FAIL midreset_product: got=%h expected=0000", product); end
    @(negedge clk);
    reset = 1'b0;
    run_op(8'h02, 8'h03, 1'b0, ok);
    total += 1;
    if (!ok) begin bad += 1; $display("FAIL after_reset_timeout: done got=0 expected=1"); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    frac = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_int_latency;
    test_signed;
    test_frac;
    test_saturation;
    test_busy_start;
    test_back_to_back;
    test_reset_mid;
    repeat (3) @(negedge clk);
    total += 1;
    if (sb.size() != 0) begin bad += 1; $display("FAIL scoreboard_drain: pending got=%0d expected=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
